// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared definitions for the two-requester RAM arbiter:
//                default bus widths and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

    localparam int C_DATA_W_DEF = 16;
    localparam int C_ADDR_W_DEF = 8;

    // Sequencer states. ISSUE carries the RAM strobes and CAPTURE exists
    // only for reads. ACK carries the single-cycle completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_e;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Bundle of the requester handshakes and the RAM-side bus.
//                The slave modport is the arbiter view. The master modport
//                is the view of the environment, which is the two
//                requesters plus the RAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEF,
    parameter int ADDR_W = C_ADDR_W_DEF
) ();

    // Requester 0 / 1 command side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;

    // Requester 0 / 1 completion side
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // RAM side
    logic              ram_init;
    logic              ram_wr;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output ack0, ack1, rdata0, rdata1,
        output ram_init, ram_wr, ram_rd, ram_addr, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  ack0, ack1, rdata0, rdata1,
        input  ram_init, ram_wr, ram_rd, ram_addr, ram_wdata
    );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin picker. A lone requester
//                always wins. On contention, the requester that was not
//                granted last time wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic            grant,
    output logic            valid
);

    // Pick the winner index from the request pair and the previous winner.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-requester round-robin arbiter in front of a
//                single-port RAM that has a registered read output. Only one
//                operation is in flight at a time.
//                Write latency: IDLE -> ISSUE -> ACK.
//                Read latency:  IDLE -> ISSUE -> CAPTURE -> ACK.
//                Every output comes from a flop.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEF,
    parameter int ADDR_W = C_ADDR_W_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ram_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                win_q,        win_d;      // winner of the current op
    logic                cmd_we_q,     cmd_we_d;   // latched write flag
    logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d; // doubles as the address latch
    logic [DATA_W-1:0]   ram_wdata_q,  ram_wdata_d;// doubles as the data latch
    logic                ram_init_q,   ram_init_d;
    logic                ram_wr_q,     ram_wr_d;
    logic                ram_rd_q,     ram_rd_d;
    logic                ack0_q,       ack0_d;
    logic                ack1_q,       ack1_d;
    logic [DATA_W-1:0]   rdata0_q,     rdata0_d;
    logic [DATA_W-1:0]   rdata1_q,     rdata1_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                w_grant;
    logic                w_any_req;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.req1, bus.req0}),
        .last_grant (last_grant_q),
        .grant      (w_grant),
        .valid      (w_any_req)
    );

    // Command fields of the requester that the picker selected
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // Steer the winner's command fields toward the latches.
    always_comb begin
        w_sel_we    = w_grant ? bus.we1    : bus.we0;
        w_sel_addr  = w_grant ? bus.addr1  : bus.addr0;
        w_sel_wdata = w_grant ? bus.wdata1 : bus.wdata0;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        cmd_we_d     = cmd_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        // Strobes and acks are single-cycle pulses, so they default low.
        ram_init_d   = 1'b0;
        ram_wr_d     = 1'b0;
        ram_rd_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    win_d        = w_grant;
                    last_grant_d = w_grant;
                    cmd_we_d     = w_sel_we;
                    ram_addr_d   = w_sel_addr;
                    ram_wdata_d  = w_sel_wdata;
                    ram_init_d   = 1'b1;
                    ram_wr_d     = w_sel_we;
                    ram_rd_d     = ~w_sel_we;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A write is complete once the strobe edge has passed.
                // A read must wait one more cycle for the RAM output
                // register to fill.
                if (cmd_we_q) begin
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (win_q) begin
                    rdata1_d = bus.ram_rdata;
                end else begin
                    rdata0_d = bus.ram_rdata;
                end
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                state_d = ST_ACK;
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and output registers. Reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            cmd_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_init_q   <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            cmd_we_q     <= cmd_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_init_q   <= ram_init_d;
            ram_wr_q     <= ram_wr_d;
            ram_rd_q     <= ram_rd_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.ram_init  = ram_init_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.ram_rd    = ram_rd_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. It contains a RAM with
//                a registered read output and a transaction-level reference
//                model, and drives directed plus random requester traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM with a registered read port. Its contents survive reset.
    // ------------------------------------------------------------------
    logic [DW-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_init && bus.ram_wr) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_init && bus.ram_rd) bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    // ------------------------------------------------------------------
    // Reference model, at transaction level. A granted operation occupies
    // m_len cycles: a write takes 2 and a read takes 3. The strobes are in
    // cycle 1 and the ack is in the last cycle. The model keeps a shadow
    // memory of its own.
    // ------------------------------------------------------------------
    int            m_len = 0;
    int            m_el  = 0;
    bit            m_win  = 1'b0;
    bit            m_last = 1'b1;
    bit            m_we   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rexp  = '0;
    logic [DW-1:0] m_rd [2] = '{default: '0};
    logic [DW-1:0] shadow [256] = '{default: '0};
    int            ack_log [$];
    bit            exp_stb;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_len = 0; m_el = 0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
        end else if (m_len == 0) begin
            if (bus.req0 || bus.req1) begin
                m_win   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                m_last  = m_win;
                m_we    = m_win ? bus.we1 : bus.we0;
                m_addr  = m_win ? bus.addr1 : bus.addr0;
                m_wdata = m_win ? bus.wdata1 : bus.wdata0;
                m_len   = m_we ? 2 : 3;
                m_el    = 1;
                if (m_we) shadow[m_addr] = m_wdata;
                else      m_rexp = shadow[m_addr];
            end
        end else if (m_el == m_len) begin
            m_len = 0; m_el = 0;
        end else begin
            m_el++;
            if (m_el == m_len && !m_we) m_rd[m_win] = m_rexp;
        end

        #2;
        exp_stb = (m_len != 0) && (m_el == 1);
        chk("ram_init",  32'(bus.ram_init),  32'(exp_stb));
        chk("ram_wr",    32'(bus.ram_wr),    32'(exp_stb && m_we));
        chk("ram_rd",    32'(bus.ram_rd),    32'(exp_stb && !m_we));
        chk("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
        chk("ack0", 32'(bus.ack0), 32'((m_len != 0) && (m_el == m_len) && !m_win));
        chk("ack1", 32'(bus.ack1), 32'((m_len != 0) && (m_el == m_len) &&  m_win));
        chk("rdata0", 32'(bus.rdata0), 32'(m_rd[0]));
        chk("rdata1", 32'(bus.rdata1), 32'(m_rd[1]));
        chk("proto_wr_rd",   32'(bus.ram_wr && bus.ram_rd), 32'(0));
        chk("proto_no_init", 32'((bus.ram_wr || bus.ram_rd) && !bus.ram_init), 32'(0));
        chk("proto_ack_both", 32'(bus.ack0 && bus.ack1), 32'(0));
        if (bus.ack0) ack_log.push_back(0);
        if (bus.ack1) ack_log.push_back(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic clear_reqs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    // Issue one operation from a single requester. Report the ack latency
    // in falling edges, the number of strobe cycles, and the read data.
    task automatic do_op(input bit who, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output int lat, output int nstb,
                         output logic [DW-1:0] rd);
        lat = -1; nstb = 0; rd = '0;
        if (who) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data; end
        else     begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data; end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.ram_wr || bus.ram_rd) begin
                nstb++;
                chk("op_stb_addr", 32'(bus.ram_addr), 32'(addr));
                if (we) chk("op_stb_wdata", 32'(bus.ram_wdata), 32'(data));
            end
            if ((who && bus.ack1) || (!who && bus.ack0)) begin
                lat = n;
                rd  = who ? bus.rdata1 : bus.rdata0;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL op_timeout: no ack for requester %0d within 20 cycles", who);
        end
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    // Raise both requests together and collect the first nacks ack owners.
    // If drop is set, each requester drops its request after its ack.
    task automatic run_pair(input int nacks, input bit drop, input bit we,
                            output int seq [8]);
        int got;
        got = 0;
        for (int i = 0; i < 8; i++) seq[i] = -1;
        bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = 8'h20; bus.wdata0 = 16'h1111;
        bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = 8'h21; bus.wdata1 = 16'h2222;
        if (!we) begin bus.addr0 = 8'h12; bus.addr1 = 8'h12; end
        for (int n = 0; n < 60 && got < nacks; n++) begin
            @(negedge clk);
            if (bus.ack0) begin seq[got] = 0; got++; if (drop) bus.req0 = 1'b0; end
            if (bus.ack1 && got < 8) begin seq[got] = 1; got++; if (drop) bus.req1 = 1'b0; end
        end
        if (got < nacks) begin
            n_cmp++; n_err++;
            $display("FAIL pair_timeout: got %0d acks, needed %0d", got, nacks);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int            lat, nstb, nlog;
        logic [DW-1:0] rd;
        int            seq [8];

        clear_reqs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack0",     32'(bus.ack0),      32'(0));
        chk("rst_ack1",     32'(bus.ack1),      32'(0));
        chk("rst_ram_init", 32'(bus.ram_init),  32'(0));
        chk("rst_ram_addr", 32'(bus.ram_addr),  32'(0));
        chk("rst_rdata0",   32'(bus.rdata0),    32'(0));
        rst_n = 1'b1;

        // Single write, then read it back from the other requester.
        do_op(1'b0, 1'b1, 8'h12, 16'hBEEF, lat, nstb, rd);
        chk("wr_latency", 32'(lat),  32'(2));
        chk("wr_strobes", 32'(nstb), 32'(1));
        @(negedge clk);
        do_op(1'b1, 1'b0, 8'h12, 16'h0000, lat, nstb, rd);
        chk("rd_latency", 32'(lat),  32'(3));
        chk("rd_strobes", 32'(nstb), 32'(1));
        chk("rd_data",    32'(rd),   32'(16'hBEEF));

        // Contention straight out of reset: requester 0 goes first.
        pulse_reset();
        run_pair(2, 1'b1, 1'b1, seq);
        chk("contend_first",  32'(seq[0]), 32'(0));
        chk("contend_second", 32'(seq[1]), 32'(1));

        // Both requesters keep requesting: the grants must alternate.
        @(negedge clk);
        run_pair(6, 1'b0, 1'b0, seq);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_%0d", i), 32'(seq[i]), 32'(i % 2));

        // Reset during CAPTURE of a read: all outputs clear and no ack.
        repeat (2) @(negedge clk);
        nlog = ack_log.size();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h12;
        repeat (2) @(negedge clk);                 // now inside CAPTURE
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("abort_ram_init", 32'(bus.ram_init), 32'(0));
        chk("abort_ack0",     32'(bus.ack0),     32'(0));
        chk("abort_rdata0",   32'(bus.rdata0),   32'(0));
        chk("abort_rdata1",   32'(bus.rdata1),   32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_ack", 32'(ack_log.size()), 32'(nlog));
        do_op(1'b0, 1'b0, 8'h12, 16'h0000, lat, nstb, rd);
        chk("post_rst_latency", 32'(lat), 32'(3));
        chk("post_rst_data",    32'(rd),  32'(16'hBEEF));

        // Random traffic. Each requester holds its request until ack and
        // may chain a new request straight after that ack.
        @(negedge clk);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (bus.req0 && bus.ack0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.we0 = 1'($urandom); bus.addr0 = 8'($urandom_range(0, 15));
                    bus.wdata0 = 16'($urandom);
                end else bus.req0 = 1'b0;
            end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'($urandom);
                bus.addr0 = 8'($urandom_range(0, 15)); bus.wdata0 = 16'($urandom);
            end
            if (bus.req1 && bus.ack1) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.we1 = 1'($urandom); bus.addr1 = 8'($urandom_range(0, 15));
                    bus.wdata1 = 16'($urandom);
                end else bus.req1 = 1'b0;
            end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1 = 1'b1; bus.we1 = 1'($urandom);
                bus.addr1 = 8'($urandom_range(0, 15)); bus.wdata1 = 16'($urandom);
            end
        end
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, RAM word width.
REQ-002 Parameter ADDR_W, default 8, RAM address width (256 words).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1; held high until matching ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0 / addr1  input  ADDR_W  word address; stable while req high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; stable while req high.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata0 / rdata1  output  DATA_W  read result; valid in the ack cycle, held until the next read completion for that requester.
REQ-011 ram_init  output  1  RAM enable, to the RAM init input.
REQ-012 ram_wr / ram_rd  output  1  RAM write / read strobes.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_wdata  output  DATA_W  to the RAM data input.
REQ-015 ram_rdata  input  DATA_W  from the RAM registered data output.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, ACK.
REQ-017 IDLE: if any req is high, pick the winner, latch its we/addr/wdata, register ram_init=1 with ram_wr=we or ram_rd=~we, and go to ISSUE; otherwise stay in IDLE with all RAM strobes 0.
REQ-018 ISSUE lasts exactly one cycle, with strobes valid throughout. On exit, strobes and ram_init return to 0. A write goes to ACK; a read goes to CAPTURE.
REQ-019 CAPTURE: the RAM output is valid. At the end of the cycle, register ram_rdata into the winner's rdata and go to ACK.
REQ-020 ACK: assert only the winner's ack for exactly one cycle, then go to IDLE.
REQ-021 Latency SHALL be fixed: with req sampled in IDLE at edge E, a write ack is high in cycle E+2 and a read ack in cycle E+3.
REQ-022 Arbitration SHALL be round-robin. On simultaneous req0 and req1, grant the requester not granted last. A single requester is always granted. last_grant resets to 1, so requester 0 wins the first contention.
REQ-023 Only one RAM operation SHALL be outstanding at a time. A request arriving outside IDLE waits; it is not dropped.
REQ-024 A req still high in the IDLE cycle after its ack SHALL be treated as a new request and arbitrated normally.
REQ-025 ram_wr and ram_rd SHALL never be high together. Neither SHALL be high without ram_init.
REQ-026 Command latches SHALL NOT change between IDLE exit and ACK exit, even if inputs change.
REQ-027 Any assertion of rst_n=0 mid-operation SHALL abort immediately. An aborted write may or may not reach RAM. No ack is issued for the aborted operation.

Reset
REQ-028 While rst_n=0, the block SHALL be held as follows:
- FSM = IDLE
- ack0, ack1, ram_init, ram_wr, ram_rd = 0
- ram_addr, ram_wdata, rdata0, rdata1 = 0
- last_grant = 1
REQ-029 Reset deassertion SHALL be treated as synchronous to clk by the system. The first request may be sampled on the first edge after release.

Structure
REQ-030 Shared package ram_arb_pkg SHALL hold the state encoding (2-bit enum) and the DATA_W/ADDR_W defaults.
REQ-031 A sub-module rr_arb2 (combinational two-way round-robin picker: req[1:0], last_grant -> grant index) SHALL hold the arbitration logic. The FSM and all registers stay in ram_arbiter.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Write: req0, we0=1, addr0=0x12, wdata0=0xBEEF -> ram_wr=1 with ram_addr=0x12 and ram_wdata=0xBEEF for one cycle; ack0 at E+2.
REQ-034 Read-back: req1, we1=0, addr1=0x12 after REQ-033 -> ram_rd=1 for one cycle; rdata1=0xBEEF with ack1 at E+3.
REQ-035 Contention: req0 and req1 rise in the same cycle from reset -> requester 0 served first, then requester 1; ack pulses never overlap.
REQ-036 Fairness: req0 and req1 held high continuously for 6 operations -> acks strictly alternate 0,1,0,1,0,1.
REQ-037 Reset mid-read: rst_n=0 during CAPTURE -> all outputs 0 on the next sample, no ack; after release a fresh read of 0x12 returns 0xBEEF.
REQ-038 Protocol check on every cycle: never ram_wr and ram_rd together, never a strobe without ram_init, never ack0 and ack1 together.
